// File: rtl/bms_balance_ctrl.sv
// -----------------------------------------------------------------------------
// bms_balance_ctrl
// Sequencing controller for the 4-cell current-distribution datapath.
// Samples the pack current-sign flags, drives the datapath mode select (sel)
// and zero-current force (eqz), waits DP_LAT cycles for the divider/reciprocal
// chain to settle, then pulses cap_en to latch the per-cell currents.
// Runs once on start, or repeatedly every PERIOD+DP_LAT+2 cycles while enable
// is high. A sign change must be seen HYST times in a row before sel flips.
//
// Parameters:
//   DP_LAT  settle cycles between sel/eqz update and capture (1..255)
//   PERIOD  idle cycles in WAIT between periodic samples    (1..65535)
//   HYST    consecutive opposite-sign samples to flip sel   (1..15)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   single-shot request (only honoured in IDLE)
//   enable  in   periodic mode, level sensitive
//   gt/eq/lt in  pack current sign flags from the datapath (expected one-hot)
//   sel     out  0 = SOC-proportional (discharge), 1 = reciprocal-SOC (charge)
//   eqz     out  force datapath per-cell outputs to zero
//   cap_en  out  one-cycle capture strobe
//   valid   out  high from the first capture until reset
//   busy    out  high in SAMPLE, SETTLE, CAPTURE
//   state   out  IDLE=0, SAMPLE=1, SETTLE=2, CAPTURE=3, WAIT=4
//   fault   out  (only with BMS_FLAG_CHECK_EN) sticky non-one-hot flag alarm
//
// Optional feature macro: BMS_FLAG_CHECK_EN
//   When defined, a non-one-hot flag set seen in SAMPLE sets the sticky fault
//   output; while fault is set, eqz is forced high and sel is frozen.
// -----------------------------------------------------------------------------
module bms_balance_ctrl #(
  parameter int DP_LAT = 4,
  parameter int PERIOD = 16,
  parameter int HYST   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic       gt,
  input  logic       eq,
  input  logic       lt,
  output logic       sel,
  output logic       eqz,
  output logic       cap_en,
  output logic       valid,
  output logic       busy,
  output logic [2:0] state
`ifdef BMS_FLAG_CHECK_EN
  ,
  output logic       fault
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  // One counter is shared: it times SETTLE, then WAIT; the two never overlap.
  localparam logic [15:0] SETTLE_LOAD = 16'(DP_LAT - 1);
  localparam logic [15:0] PERIOD_LOAD = 16'(PERIOD - 1);
  localparam logic [3:0]  HYST_LIM    = 4'(HYST);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        eqz_q, eqz_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [3:0]  hyst_q, hyst_d;
  logic [3:0]  hyst_inc;
  logic        one_hot;
  logic        sign_ok;
  logic        target;
  logic        fault_act;

  // Exactly one flag set: odd parity rules out zero/two set, the AND rules
  // out all three.
  assign one_hot = (gt ^ eq ^ lt) & ~(gt & eq & lt);
  assign target  = lt;
  assign hyst_inc = hyst_q + 4'd1;

`ifdef BMS_FLAG_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (state_q == S_SAMPLE && !one_hot) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_act = fault_q;
  assign fault     = fault_q;
`else
  assign fault_act = 1'b0;
`endif

  // A usable sign sample: one-hot, not zero-current, and not locked by fault.
  assign sign_ok = one_hot & ~eq & ~fault_act;

  // ---------------------------------------------------------------------------
  // State register (plus the registered datapath controls)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      eqz_q   <= 1'b1;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      hyst_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      eqz_q   <= eqz_d;
      valid_q <= valid_d;
      first_q <= first_d;
      hyst_q  <= hyst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start || enable) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (enable) begin
          state_d = S_WAIT;
          cnt_d   = PERIOD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Dropping enable wins over an expiring period.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / flag-decode logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d   = sel_q;
    eqz_d   = eqz_q;
    first_d = first_q;
    hyst_d  = hyst_q;
    valid_d = valid_q;

    if (state_q == S_SAMPLE) begin
      if (!sign_ok) begin
        // Zero current, malformed flags, or fault lock: zero the outputs and
        // keep the current mode.
        eqz_d  = 1'b1;
        hyst_d = '0;
      end else begin
        eqz_d = 1'b0;
        if (!first_q) begin
          // No history yet, so adopt the sign directly.
          sel_d   = target;
          first_d = 1'b1;
          hyst_d  = '0;
        end else if (target == sel_q) begin
          hyst_d = '0;
        end else if (hyst_inc == HYST_LIM) begin
          sel_d  = ~sel_q;
          hyst_d = '0;
        end else begin
          hyst_d = hyst_inc;
        end
      end
    end

    if (state_q == S_CAPTURE) begin
      valid_d = 1'b1;
    end
  end

  assign sel    = sel_q;
  assign eqz    = eqz_q;
  assign valid  = valid_q;
  assign state  = state_q;
  assign cap_en = (state_q == S_CAPTURE);
  assign busy   = (state_q == S_SAMPLE) || (state_q == S_SETTLE) ||
                  (state_q == S_CAPTURE);

endmodule

// File: tb/tb_bms_balance_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for bms_balance_ctrl. Directed sequence plus randomized periodic
// sampling, checked against a rule-level model of the sign decode and of the
// capture timing (latency DP_LAT+2, spacing PERIOD+DP_LAT+2).
// -----------------------------------------------------------------------------
module tb_bms_balance_ctrl;
  localparam int DP_LAT = 4;
  localparam int PERIOD = 16;
  localparam int HYST   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       gt = 1'b0;
  logic       eq = 1'b0;
  logic       lt = 1'b0;
  logic       sel, eqz, cap_en, valid, busy;
  logic [2:0] state;
`ifdef BMS_FLAG_CHECK_EN
  logic       fault;
`endif

  bms_balance_ctrl #(.DP_LAT(DP_LAT), .PERIOD(PERIOD), .HYST(HYST)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable),
    .gt(gt), .eq(eq), .lt(lt),
    .sel(sel), .eqz(eqz), .cap_en(cap_en), .valid(valid), .busy(busy),
    .state(state)
`ifdef BMS_FLAG_CHECK_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_cap = -1;

  // Reference model of the sign-decode rules
  bit m_sel, m_eqz, m_first, m_fault;
  int m_hc;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_eqz = 1; m_first = 0; m_fault = 0; m_hc = 0;
  endtask

  task automatic model_sample(input bit g, input bit e, input bit l);
    int nset;
    nset = int'(g) + int'(e) + int'(l);
`ifdef BMS_FLAG_CHECK_EN
    if (nset != 1) m_fault = 1;
    if (m_fault || e || nset != 1) begin
`else
    if (e || nset != 1) begin
`endif
      m_eqz = 1;
      m_hc  = 0;
    end else begin
      m_eqz = 0;
      if (!m_first) begin
        m_sel = l; m_first = 1; m_hc = 0;
      end else if (l == m_sel) begin
        m_hc = 0;
      end else begin
        m_hc = m_hc + 1;
        if (m_hc == HYST) begin
          m_sel = ~m_sel;
          m_hc  = 0;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
    chk({tag, "_eqz"}, 32'(eqz), 32'(m_eqz));
`ifdef BMS_FLAG_CHECK_EN
    chk({tag, "_fault"}, 32'(fault), 32'(m_fault));
`endif
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state !== s && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_reach_state"}, 32'(state), 32'(s));
  endtask

  // Waits for cap_en; checks spacing to the previous capture when tracked.
  task automatic wait_cap(input string tag);
    int n;
    n = 0;
    while (cap_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_cap_seen"}, 32'(cap_en), 32'd1);
    if (prev_cap >= 0)
      chk({tag, "_cap_spacing"}, 32'(cyc - prev_cap), 32'(PERIOD + DP_LAT + 2));
    prev_cap = cyc;
  endtask

  // Called in the SAMPLE cycle: present flags, advance, compare decode.
  task automatic do_sample(input bit g, input bit e, input bit l, input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    gt = g; eq = e; lt = l;
    model_sample(g, e, l);
    tick();
    chk({tag, "_settle"}, 32'(state), 32'd2);
    check_model(tag);
    $display("sample %s flags gt=%0b eq=%0b lt=%0b -> sel=%0b eqz=%0b @%0d",
             tag, g, e, l, sel, eqz, cyc);
  endtask

  task automatic shot(input bit g, input bit e, input bit l, input string tag);
    int c0;
    c0 = cyc;
    start = 1;
    tick();
    start = 0;
    chk({tag, "_sample"}, 32'(state), 32'd1);
    do_sample(g, e, l, tag);
    prev_cap = -1;
    wait_cap(tag);
    chk({tag, "_latency"}, 32'(cyc - c0), 32'(DP_LAT + 2));
    tick();
    chk({tag, "_cap_pulse"}, 32'(cap_en), 32'd0);
    chk({tag, "_idle"}, 32'(state), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  task automatic periodic_sample(input bit g, input bit e, input bit l, input string tag);
    wait_state(3'd1, tag);
    do_sample(g, e, l, tag);
    wait_cap(tag);
  endtask

  task automatic stop_periodic(input string tag);
    int caps;
    wait_state(3'd4, tag);
    enable = 0;
    tick();
    chk({tag, "_stop_idle"}, 32'(state), 32'd0);
    caps = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cap_en === 1'b1) caps++;
    end
    chk({tag, "_no_cap"}, 32'(caps), 32'd0);
    prev_cap = -1;
  endtask

  initial begin
    bit g, e, l;
    int r, caps;

    // Reset state
    model_reset();
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_eqz", 32'(eqz), 32'd1);
    chk("rst_cap", 32'(cap_en), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef BMS_FLAG_CHECK_EN
    chk("rst_fault", 32'(fault), 32'd0);
`endif
    rst = 0;
    tick();

    // Single shot with discharge current
    shot(1, 0, 0, "shot_gt");
    chk("shot_gt_sel0", 32'(sel), 32'd0);

    // Fresh start: first sign lt adopted directly, then hysteresis sequence
    rst = 1; tick(); rst = 0; model_reset(); tick();
    shot(0, 0, 1, "first_lt");
    chk("first_lt_sel1", 32'(sel), 32'd1);
    enable = 1;
    prev_cap = -1;
    periodic_sample(1, 0, 0, "hy1");
    periodic_sample(1, 0, 0, "hy2");
    periodic_sample(0, 0, 1, "hy3");
    periodic_sample(1, 0, 0, "hy4");
    periodic_sample(1, 0, 0, "hy5");
    chk("hy5_sel_held", 32'(sel), 32'd1);
    periodic_sample(1, 0, 0, "hy6");
    chk("hy6_sel_flip", 32'(sel), 32'd0);

    // Zero-current sample clears the count
    periodic_sample(0, 0, 1, "eq1");
    periodic_sample(0, 0, 1, "eq2");
    periodic_sample(0, 1, 0, "eq3");
    chk("eq3_eqz", 32'(eqz), 32'd1);
    periodic_sample(0, 0, 1, "eq4");
    periodic_sample(0, 0, 1, "eq5");
    chk("eq5_sel_held", 32'(sel), 32'd0);
    periodic_sample(0, 0, 1, "eq6");
    chk("eq6_sel_flip", 32'(sel), 32'd1);
    stop_periodic("p1");

    // Randomized periodic run
    enable = 1;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       begin g = 1; e = 0; l = 0; end
      else if (r < 12) begin g = 0; e = 0; l = 1; end
      else if (r < 14) begin g = 0; e = 1; l = 0; end
      else if (r == 14) begin g = 0; e = 0; l = 0; end
      else             begin g = 1; e = 0; l = 1; end
      periodic_sample(g, e, l, $sformatf("rnd%0d", i));
    end
    stop_periodic("p2");

    // Reset during SETTLE drops the sequence
    start = 1; tick(); start = 0;
    tick();
    chk("abort_in_settle", 32'(state), 32'd2);
    rst = 1; tick(); rst = 0;
    model_reset();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_eqz", 32'(eqz), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    caps = 0;
    for (int i = 0; i < 20; i++) begin
      if (cap_en === 1'b1) caps++;
      tick();
    end
    chk("abort_no_cap", 32'(caps), 32'd0);

    // Malformed flags
    shot(1, 0, 0, "bad_pre");
    shot(1, 0, 1, "bad_gtlt");
    chk("bad_gtlt_eqz", 32'(eqz), 32'd1);
    chk("bad_gtlt_sel", 32'(sel), 32'd0);
    shot(0, 0, 1, "bad_post");
    shot(1, 0, 0, "bad_post2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bms_balance_ctrl.md
Name: bms_balance_ctrl

Overview:
- Sequencing controller for the 4-cell current-distribution datapath.
- Samples the datapath's current-sign flags (gt/eq/lt) and drives the mode select (sel) and zero-current force (eqz) into the datapath.
- Waits a fixed settle time for the divider/reciprocal chain, then pulses a capture enable that latches the four per-cell currents.
- Runs single-shot on start, or periodically while enable is high; applies sign hysteresis so sel cannot chatter.

Parameters:
DP_LAT, 4, datapath settle cycles between sel/eqz update and capture; legal range 1..255.
PERIOD, 16, idle cycles in WAIT between periodic samples; legal range 1..65535.
HYST, 3, consecutive opposite-sign samples required to flip sel; legal range 1..15; 1 = immediate flip.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-shot request; sampled only in IDLE.
enable  in  1  periodic mode; level.
gt  in  1  datapath flag: pack current > 0 (discharge).
eq  in  1  datapath flag: pack current == 0.
lt  in  1  datapath flag: pack current < 0 (charge).
sel  out  1  datapath mode: 0 = SOC-proportional (discharge), 1 = reciprocal-SOC (charge).
eqz  out  1  forces datapath per-cell outputs to the zero constant.
cap_en  out  1  one-cycle pulse; latch datapath per-cell outputs.
valid  out  1  high from the first capture until rst.
busy  out  1  high in SAMPLE, SETTLE, CAPTURE.
state  out  3  FSM state: IDLE=0, SAMPLE=1, SETTLE=2, CAPTURE=3, WAIT=4.

Behaviour:
Reset values (rst high at any clock edge, including mid-operation; takes effect next cycle):
- state=IDLE, sel=0, eqz=1, cap_en=0, valid=0, busy=0, hysteresis count=0, first flag=0.
- A sequence in progress is dropped and produces no cap_en.

FSM transitions:
- IDLE: (start | enable) -> SAMPLE. start while busy or in WAIT is ignored.
- SAMPLE: one cycle. Flags decoded at the end of the cycle; sel/eqz are registered and change at that edge. Settle counter loaded with DP_LAT-1. -> SETTLE.
- SETTLE: exactly DP_LAT cycles, counting down; at 0 -> CAPTURE.
- CAPTURE: one cycle with cap_en=1; valid<=1. enable ? WAIT : IDLE.
- WAIT: period counter loaded with PERIOD-1 on entry.
  - enable low -> IDLE on the next edge.
  - count reaches 0 -> SAMPLE.

Latency and period:
- start high in cycle n (IDLE) -> SAMPLE in n+1, sel/eqz valid in n+2, cap_en in cycle n+2+DP_LAT.
- Periodic capture-to-capture spacing = PERIOD+DP_LAT+2 cycles.

Flag decode in SAMPLE (flags expected one-hot):
- eq: eqz=1; sel held; hysteresis count cleared.
- gt or lt: eqz=0. The target sel is 0 for gt and 1 for lt.
- First valid sign sample since reset (first flag=0): sel takes the target directly, first flag set, count=0.
- Target == sel: count cleared.
- Target != sel: count+1. When the count reaches HYST, sel flips and count=0.
- Non-one-hot flags (none set, or more than one set): treated as eq.

Other rules:
- enable and start together in IDLE: one sequence, continuing periodically.
- Counters saturate-free: they never wrap, because their load values are bounded by the parameter ranges.

Optional Feature:
BMS_FLAG_CHECK_EN
- Defined: adds output fault (1 bit, reset 0). A non-one-hot flag set seen in SAMPLE sets fault sticky until rst. While fault=1, eqz is forced to 1 and sel is held; the FSM still sequences and captures.
- Undefined: no fault port. Non-one-hot flags are handled as eq only.

Test Plan:
- rst, then start=1 for 1 cycle with gt=1, DP_LAT=4 -> sel=0, eqz=0 two cycles after start; cap_en high exactly 6 cycles after start for 1 cycle; valid=1 thereafter; state returns to 0.
- First sample lt=1 -> sel=1. Then enable=1, HYST=3, samples gt,gt,lt,gt,gt,gt -> sel stays 1 through the fifth sample and flips to 0 after the sixth.
- sel=1, sample eq=1 -> eqz=1, sel stays 1. A following gt sample restarts the hysteresis count from 1.
- enable=1, PERIOD=16, DP_LAT=4 -> cap_en pulses every 22 cycles. Dropping enable in WAIT -> state=0 on the next cycle, no further cap_en.
- rst pulsed during SETTLE -> next cycle state=0, sel=0, eqz=1, busy=0, valid=0; no cap_en from the aborted sequence.
- Sample with gt=lt=1 -> eqz=1, sel held. With BMS_FLAG_CHECK_EN: fault=1 and stays 1 across later valid gt samples until rst.
